rv32_hart_sched: RTL
====================

# rv32_hart_sched

Round-robin hart scheduler for the barrel-threaded RV32 core. It holds a PC and a run state for each hart, and issues one ready hart per cycle into the fetch/decode pipeline. It retires each issued hart when the writeback stage returns that hart's next PC. A decode trap parks the hart in HALTED until the host restarts it, so a bad instruction in one hart never stalls the others.

## Interface
- NUM_HARTS, 8, number of hardware harts (power of two, 2..32)
- HID_W, $clog2(NUM_HARTS), hart-id width (derived, not overridden)
- RESET_PC, 32'h0000_0000, PC loaded into every hart on reset
- clk  in  1  core clock; the only clock
- rst  in  1  reset, synchronous, active-high
- issue_stall  in  1  pipeline cannot accept an issue this cycle
- issue_valid  out  1  registered one-cycle issue pulse
- issue_hart  out  HID_W  hart issued
- issue_pc  out  32  PC of the issued hart
- wb_valid  in  1  writeback completion for one hart
- wb_hart  in  HID_W  completing hart
- wb_next_pc  in  32  next PC for that hart
- wb_trap  in  1  instr_trap from the decoder, carried to writeback with the instruction
- ctl_start  in  1  host start/restart command
- ctl_hart  in  HID_W  target hart of ctl_start
- ctl_pc  in  32  start PC
- trap_valid  out  1  registered one-cycle trap pulse
- trap_hart  out  HID_W  trapping hart
- trap_pc  out  32  PC of the trapping instruction
- halted_mask  out  NUM_HARTS  bit h set when hart h is HALTED
- active_mask  out  NUM_HARTS  bit h set when hart h is READY or WAIT

## Operation
- Each hart has a 2-bit state (IDLE, READY, WAIT, HALTED) and a 32-bit pc register.
- IDLE -> READY on ctl_start for that hart; pc <= ctl_pc.
- HALTED -> READY on ctl_start for that hart; pc <= ctl_pc.
- ctl_start aimed at a READY or WAIT hart is ignored. Its state and pc are unchanged.
- READY -> WAIT when the hart is selected for issue.
- WAIT -> READY on wb_valid with wb_trap=0; pc <= wb_next_pc.
- WAIT -> HALTED on wb_valid with wb_trap=1. pc is unchanged and keeps the trapping PC. trap_valid, trap_hart and trap_pc are registered.
- wb_valid aimed at a hart not in WAIT is ignored, and no trap is reported.
- Selection:
  - A pointer `last` holds the most recently issued hart; it resets to NUM_HARTS-1.
  - The candidate is the first READY hart scanning last+1, last+2, ... modulo NUM_HARTS.
  - No selection is made when issue_stall=1 or when no hart is READY. `last` is unchanged in that case.
- Selection uses state as it stands before the current edge. A hart returning via wb or ctl_start in cycle t is first eligible in cycle t+1.
- ctl_start and wb_valid in the same cycle for different harts are both applied.
- The same hart cannot legally receive both in one cycle: ctl_start is ignored in WAIT, and wb_valid is ignored outside WAIT.
- Reset loads all harts IDLE with pc=RESET_PC and sets last=NUM_HARTS-1. It clears issue_valid and trap_valid, and zeroes issue_hart, issue_pc, trap_hart and trap_pc.
- Reset asserted mid-operation discards all in-flight state. A wb_valid arriving after reset is ignored because no hart is in WAIT.

## Timing
- Issue latency: a selection in cycle t produces issue_valid=1 in cycle t+1, together with issue_hart and the pc that was sampled at t.
- issue_valid is a pulse with no back-pressure. issue_stall only gates new selections.
- Start to issue: ctl_start at t gives READY at t+1, selection at t+1, and issue_valid at t+2 (minimum, when unstalled).
- Retire to reissue: wb_valid at t gives READY at t+1 and issue_valid at t+2 (minimum).
- Trap report: wb_valid with wb_trap at t gives trap_valid at t+1. halted_mask is updated at t+1.
- halted_mask and active_mask are decoded from registered state, with no combinational path from inputs.
- Throughput is at most one issue per cycle. With all harts READY and no stall, issue_hart runs 0,1,...,NUM_HARTS-1,0,...

## Test plan
- Reset, then ctl_start hart 0 with pc 0x100 at cycle 1 -> issue_valid at cycle 3 with hart 0 and pc 0x100. Before reset completes, issue_valid, trap_valid and both masks are 0.
- Start all 8 harts in consecutive cycles, then loopback writeback 2 cycles after each issue with next_pc=pc+4 -> issue order is strictly 0..7 repeated. Each hart's pc advances by 4 per issue, and no hart is issued while in WAIT.
- Hold issue_stall=1 for 5 cycles with harts 2 and 5 READY and last=2 -> no issue_valid during the stall. The first issue after release is hart 5, then hart 2.
- Writeback for hart 3 (pc 0x40) with wb_trap=1 -> trap_valid=1 next cycle with trap_hart 3 and trap_pc 0x40, and halted_mask=8'h08. Other harts keep issuing. ctl_start hart 3 with pc 0x200 -> hart 3 issues at 0x200 and its halted bit clears.
- ctl_start to a WAIT hart, plus wb_valid to an IDLE hart -> both ignored: state, pc and the masks are unchanged, and no trap pulse.
- Assert rst for 1 cycle while 4 harts are in WAIT -> all harts IDLE with pc=RESET_PC. Late wb_valid pulses for those harts are ignored. The first issue after a new ctl_start is the started hart.

Source files
------------

// File: rtl/rv32_hart_sched.sv
// Round-robin hart scheduler for the barrel-threaded RV32 core.
// Tracks per-hart run state and PC, issues one READY hart per cycle, retires on writeback.
module rv32_hart_sched #(
    parameter int          NUM_HARTS = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    localparam int         HID_W     = $clog2(NUM_HARTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_stall,
    output logic                 issue_valid,
    output logic [HID_W-1:0]     issue_hart,
    output logic [31:0]          issue_pc,
    input  logic                 wb_valid,
    input  logic [HID_W-1:0]     wb_hart,
    input  logic [31:0]          wb_next_pc,
    input  logic                 wb_trap,
    input  logic                 ctl_start,
    input  logic [HID_W-1:0]     ctl_hart,
    input  logic [31:0]          ctl_pc,
    output logic                 trap_valid,
    output logic [HID_W-1:0]     trap_hart,
    output logic [31:0]          trap_pc,
    output logic [NUM_HARTS-1:0] halted_mask,
    output logic [NUM_HARTS-1:0] active_mask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        WAIT   = 2'd2,
        HALTED = 2'd3
    } hart_state_t;

    hart_state_t      state_q [NUM_HARTS];
    hart_state_t      state_d [NUM_HARTS];
    logic [31:0]      pc_q    [NUM_HARTS];
    logic [31:0]      pc_d    [NUM_HARTS];
    logic [HID_W-1:0] last_q;
    logic [HID_W-1:0] last_d;

    logic             sel_found;
    logic [HID_W-1:0] sel_hart;
    logic [HID_W-1:0] cand;
    logic             issue_go;
    logic             wb_take;
    logic             ctl_take;

    // Scan last+1 .. last+NUM_HARTS; the HID_W-bit add wraps modulo NUM_HARTS.
    always_comb begin
        sel_found = 1'b0;
        sel_hart  = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_HARTS; i++) begin
            cand = last_q + HID_W'(i);
            if (!sel_found && state_q[cand] == READY) begin
                sel_found = 1'b1;
                sel_hart  = cand;
            end
        end
    end

    assign issue_go = sel_found && !issue_stall;
    assign wb_take  = wb_valid && (state_q[wb_hart] == WAIT);
    assign ctl_take = ctl_start &&
                      (state_q[ctl_hart] == IDLE || state_q[ctl_hart] == HALTED);

    // Issue, writeback and start act on disjoint hart states, so their order here is irrelevant.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        last_d  = last_q;
        if (issue_go) begin
            state_d[sel_hart] = WAIT;
            last_d            = sel_hart;
        end
        if (wb_take) begin
            if (wb_trap) begin
                state_d[wb_hart] = HALTED;
            end else begin
                state_d[wb_hart] = READY;
                pc_d[wb_hart]    = wb_next_pc;
            end
        end
        if (ctl_take) begin
            state_d[ctl_hart] = READY;
            pc_d[ctl_hart]    = ctl_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                state_q[h] <= IDLE;
                pc_q[h]    <= RESET_PC;
            end
            last_q      <= HID_W'(NUM_HARTS - 1);
            issue_valid <= 1'b0;
            issue_hart  <= '0;
            issue_pc    <= '0;
            trap_valid  <= 1'b0;
            trap_hart   <= '0;
            trap_pc     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            last_q      <= last_d;
            issue_valid <= issue_go;
            if (issue_go) begin
                issue_hart <= sel_hart;
                issue_pc   <= pc_q[sel_hart];
            end
            trap_valid <= wb_take && wb_trap;
            if (wb_take && wb_trap) begin
                trap_hart <= wb_hart;
                trap_pc   <= pc_q[wb_hart];
            end
        end
    end

    always_comb begin
        halted_mask = '0;
        active_mask = '0;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            halted_mask[h] = (state_q[h] == HALTED);
            active_mask[h] = (state_q[h] == READY) || (state_q[h] == WAIT);
        end
    end

endmodule
